mc_alu: RTL and testbench

Parametrised, multi-cycle successor to the processor's single-cycle ALU. It executes the same 4-bit opcode set at configurable datapath width, adds an iterative multiplier (full-width overflow detection), an optional iterative divider, ASR, and a PC-relative ADR. It uses a valid/ready handshake on both sides, so the execute stage can stall on multi-cycle operations and on downstream backpressure. It sits between operand fetch and writeback and owns the NZCV flag register.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_iter_muldiv.sv | 112 +++++++++++
 rtl/mc_alu.sv | 174 +++++++++++++++++
 tb/tb_mc_alu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for mc_alu: opcodes, FSM states, flag classes and their decode.
// Optional feature macro: ALU_DIV_EN (makes DIV an iterative op that updates N, Z and V).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_ORR  = 4'd3,
    OP_AND  = 4'd4,
    OP_EOR  = 4'd5,
    OP_MOVN = 4'd6,
    OP_MOV  = 4'd7,
    OP_LSR  = 4'd8,
    OP_LSL  = 4'd9,
    OP_ROR  = 4'd10,
    OP_CMP  = 4'd11,
    OP_ADR  = 4'd12,
    OP_DIV  = 4'd13,
    OP_ASR  = 4'd14,
    OP_NOP  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_NZCV = 2'd0,
    FC_NZ_V = 2'd1,
    FC_NZ   = 2'd2,
    FC_NONE = 2'd3
  } flag_class_e;

  function automatic flag_class_e flag_class(input opcode_e op);
    flag_class_e fc;
    case (op)
      OP_ADD, OP_SUB, OP_CMP:                  fc = FC_NZCV;
      OP_MUL:                                  fc = FC_NZ_V;
`ifdef ALU_DIV_EN
      OP_DIV:                                  fc = FC_NZ_V;
`endif
      OP_ORR, OP_AND, OP_EOR,
      OP_LSR, OP_LSL, OP_ROR, OP_ASR:          fc = FC_NZ;
      default:                                 fc = FC_NONE;
    endcase
    return fc;
  endfunction

  function automatic logic is_iter_op(input opcode_e op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative engine for mc_alu: shift-add multiply and (with ALU_DIV_EN) restoring divide.
// One step per cycle; the final step is presented combinationally on res/ovf while done is high.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] opb_r;
  logic [CNT_W-1:0] cnt_r;
  logic             running_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH-1:0] mul_sreg_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] sreg_nxt_s;

`ifdef ALU_DIV_EN
  logic             div_r;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] div_acc_s;
  logic [WIDTH-1:0] div_sreg_s;
`endif

  assign done = running_r && (cnt_r == CNT_W'(WIDTH - 1));

  // One multiply (and divide) step computed from the current state.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + (sreg_r[0] ? {1'b0, opb_r} : {(WIDTH + 1){1'b0}});
    mul_acc_s  = mul_sum_s[WIDTH:1];
    mul_sreg_s = {mul_sum_s[0], sreg_r[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // A zero divisor never borrows, so the quotient naturally comes out all ones.
    div_shift_s = {acc_r, sreg_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (!div_diff_s[WIDTH]) begin
      div_acc_s  = div_diff_s[WIDTH-1:0];
      div_sreg_s = {sreg_r[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_s  = div_shift_s[WIDTH-1:0];
      div_sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
    end
    if (div_r) begin
      acc_nxt_s  = div_acc_s;
      sreg_nxt_s = div_sreg_s;
      res        = div_sreg_s;
      ovf        = (opb_r == '0);
    end else begin
      acc_nxt_s  = mul_acc_s;
      sreg_nxt_s = mul_sreg_s;
      res        = mul_sreg_s;
      ovf        = (mul_acc_s != '0);
    end
`else
    acc_nxt_s  = mul_acc_s;
    sreg_nxt_s = mul_sreg_s;
    res        = mul_sreg_s;
    ovf        = (mul_acc_s != '0);
`endif
  end

  // Load operands on start, then advance one step per cycle until the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      sreg_r    <= '0;
      opb_r     <= '0;
      cnt_r     <= '0;
      running_r <= 1'b0;
`ifdef ALU_DIV_EN
      div_r     <= 1'b0;
`endif
    end else if (start) begin
      acc_r     <= '0;
      sreg_r    <= op_a;
      opb_r     <= op_b;
      cnt_r     <= '0;
      running_r <= 1'b1;
`ifdef ALU_DIV_EN
      div_r     <= is_div;
`endif
    end else if (running_r) begin
      if (done) begin
        running_r <= 1'b0;
        cnt_r     <= '0;
      end else begin
        acc_r  <= acc_nxt_s;
        sreg_r <= sreg_nxt_s;
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready on both sides and an owned NZCV flag register.
// Optional feature macro: ALU_DIV_EN (iterative unsigned divide on opcode 13).
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [IMM_W-1:0] immediate_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_e             state_r;
  state_e             state_nxt_s;
  opcode_e            op_s;
  logic               accept_s;
  logic               start_s;
  logic               iter_done_s;
  logic [WIDTH-1:0]   iter_res_s;
  logic               iter_ovf_s;
  logic [SH_W-1:0]    sh_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [2*WIDTH-1:0] ror_s;
  logic [WIDTH-1:0]   sc_result_s;
  logic [WIDTH-1:0]   sc_flag_val_s;
  logic               sc_c_s;
  logic               sc_v_s;

  assign op_s      = opcode_e'(opcode);
  assign sh_s      = immediate_offset[SH_W-1:0];
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r == ST_BUSY);

  // Single-cycle datapath evaluated straight from the presented operands.
  always_comb begin
    add_s         = {1'b0, operand_1} + {1'b0, operand_2};
    sub_s         = {1'b0, operand_1} - {1'b0, operand_2};
    ror_s         = {operand_1, operand_1} >> sh_s;
    sc_result_s   = '0;
    sc_c_s        = 1'b0;
    sc_v_s        = 1'b0;
    case (op_s)
      OP_ADD: begin
        sc_result_s = add_s[WIDTH-1:0];
        sc_c_s      = add_s[WIDTH];
        sc_v_s      = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                      (add_s[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sc_result_s = (op_s == OP_CMP) ? '0 : sub_s[WIDTH-1:0];
        sc_c_s      = ~sub_s[WIDTH];
        sc_v_s      = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_ORR:  sc_result_s = operand_1 | operand_2;
      OP_AND:  sc_result_s = operand_1 & operand_2;
      OP_EOR:  sc_result_s = operand_1 ^ operand_2;
      OP_MOVN: sc_result_s = ~WIDTH'(immediate_offset);
      OP_MOV:  sc_result_s = operand_1;
      OP_LSR:  sc_result_s = operand_1 >> sh_s;
      OP_LSL:  sc_result_s = operand_1 << sh_s;
      OP_ROR:  sc_result_s = ror_s[WIDTH-1:0];
      OP_ASR:  sc_result_s = WIDTH'($signed(operand_1) >>> sh_s);
      OP_ADR:  sc_result_s = operand_1 + WIDTH'($signed(immediate_offset));
      default: sc_result_s = '0;
    endcase
    // CMP reports N/Z of the difference even though its result is forced to zero.
    sc_flag_val_s = (op_s == OP_CMP) ? sub_s[WIDTH-1:0] : sc_result_s;
  end

  // Handshake and next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept_s = in_valid && in_ready;
    start_s  = accept_s && is_iter_op(op_s);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = start_s ? ST_BUSY : ST_DONE;
        end else if ((state_r == ST_DONE) && out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_BUSY: begin
        if (iter_done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
`ifdef ALU_DIV_EN
    .is_div (op_s == OP_DIV),
`endif
    .op_a   (operand_1),
    .op_b   (operand_2),
    .done   (iter_done_s),
    .res    (iter_res_s),
    .ovf    (iter_ovf_s)
  );

  // State, result and NZCV; single-cycle results land on acceptance, iterative ones on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      result   <= '0;
      negative <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s && !start_s) begin
        result <= sc_result_s;
        case (flag_class(op_s))
          FC_NZCV: begin
            negative <= sc_flag_val_s[WIDTH-1];
            zero     <= (sc_flag_val_s == '0);
            carry    <= sc_c_s;
            overflow <= sc_v_s;
          end
          FC_NZ_V: begin
            negative <= sc_flag_val_s[WIDTH-1];
            zero     <= (sc_flag_val_s == '0);
            overflow <= sc_v_s;
          end
          FC_NZ: begin
            negative <= sc_flag_val_s[WIDTH-1];
            zero     <= (sc_flag_val_s == '0);
          end
          default: begin
          end
        endcase
      end else if (iter_done_s) begin
        result   <= iter_res_s;
        negative <= iter_res_s[WIDTH-1];
        zero     <= (iter_res_s == '0);
        overflow <= iter_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Table-driven, scoreboarded bench for mc_alu at WIDTH = 16 (DIV expectations follow ALU_DIV_EN).
module tb_mc_alu;

  localparam int W = 16;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  operand_1;
  logic [W-1:0]  operand_2;
  logic [6:0]    immediate_offset;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          negative, zero, carry, overflow, busy;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(W), .IMM_W(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .operand_1        (operand_1),
    .operand_2        (operand_2),
    .immediate_offset (immediate_offset),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .negative         (negative),
    .zero             (zero),
    .carry            (carry),
    .overflow         (overflow),
    .busy             (busy)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [6:0]   imm;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[21];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   next_id = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Present one op, push its expectation when accepted, then check latency.
  task automatic issue(input vec_t v);
    int   t;
    bit   iter;
    exp_t e;
    t    = 0;
    iter = (v.op == 4'd2) || ((v.op == 4'd13) && DIV_EN);
    opcode           = v.op;
    operand_1        = v.a;
    operand_2        = v.b;
    immediate_offset = v.imm;
    in_valid         = 1'b1;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check($sformatf("accept_op%0d", v.op), in_ready, 1);
    e.id = next_id; e.res = v.res; e.nzcv = v.nzcv;
    exp_q.push_back(e);
    next_id++;
    @(negedge clk);
    in_valid         = 1'b0;
    operand_1        = W'($urandom);
    operand_2        = W'($urandom);
    immediate_offset = 7'($urandom);
    if (iter) begin
      for (int k = 0; k < W; k++) begin
        check($sformatf("busy_c%0d", k), busy, 1);
        check($sformatf("in_ready_busy_c%0d", k), in_ready, 0);
        @(negedge clk);
      end
    end
    check($sformatf("out_valid_id%0d", e.id), out_valid, 1);
  endtask

  // Scoreboard: compare each result as the consumer takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result_id%0d", e.id), result, e.res);
          check($sformatf("nzcv_id%0d", e.id), {negative, zero, carry, overflow}, e.nzcv);
        end
      end
    end
  end

  initial begin
    vec_t v;
    in_valid = 1'b0; opcode = 4'd0; operand_1 = '0; operand_2 = '0;
    immediate_offset = 7'd0; out_ready = 1'b1;

    //          op     a         b         imm     result    NZCV
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 7'h00, 16'h8000, 4'b1001};
    vecs[1]  = '{4'd11, 16'h0003, 16'h0005, 7'h00, 16'h0000, 4'b1000};
    vecs[2]  = '{4'd7,  16'h1234, 16'h5555, 7'h00, 16'h1234, 4'b1000};
    vecs[3]  = '{4'd1,  16'h0005, 16'h0003, 7'h00, 16'h0002, 4'b0010};
    vecs[4]  = '{4'd0,  16'hFFFF, 16'h0001, 7'h00, 16'h0000, 4'b0110};
    vecs[5]  = '{4'd3,  16'h00F0, 16'h0F00, 7'h00, 16'h0FF0, 4'b0010};
    vecs[6]  = '{4'd4,  16'hF0F0, 16'h0FF0, 7'h00, 16'h00F0, 4'b0010};
    vecs[7]  = '{4'd5,  16'hFFFF, 16'h8000, 7'h00, 16'h7FFF, 4'b0010};
    vecs[8]  = '{4'd9,  16'h0001, 16'h0000, 7'h0F, 16'h8000, 4'b1010};
    vecs[9]  = '{4'd8,  16'h8000, 16'h0000, 7'h04, 16'h0800, 4'b0010};
    vecs[10] = '{4'd14, 16'h8000, 16'h0000, 7'h14, 16'hF800, 4'b1010};
    vecs[11] = '{4'd10, 16'h0001, 16'h0000, 7'h21, 16'h8000, 4'b1010};
    vecs[12] = '{4'd6,  16'h0000, 16'h0000, 7'h05, 16'hFFFA, 4'b1010};
    vecs[13] = '{4'd12, 16'h0100, 16'h0000, 7'h7F, 16'h00FF, 4'b1010};
    vecs[14] = '{4'd15, 16'h1111, 16'h2222, 7'h00, 16'h0000, 4'b1010};
    vecs[15] = '{4'd2,  16'h0100, 16'h0100, 7'h00, 16'h0000, 4'b0111};
    vecs[16] = '{4'd2,  16'h0003, 16'h0005, 7'h00, 16'h000F, 4'b0010};
    vecs[17] = '{4'd2,  16'hFFFF, 16'h0002, 7'h00, 16'hFFFE, 4'b1011};
`ifdef ALU_DIV_EN
    vecs[18] = '{4'd13, 16'd100,  16'd7,    7'h00, 16'h000E, 4'b0010};
    vecs[19] = '{4'd13, 16'd5,    16'd0,    7'h00, 16'hFFFF, 4'b1011};
`else
    vecs[18] = '{4'd13, 16'd100,  16'd7,    7'h00, 16'h0000, 4'b1011};
    vecs[19] = '{4'd13, 16'd5,    16'd0,    7'h00, 16'h0000, 4'b1011};
`endif
    vecs[20] = '{4'd1,  16'h8000, 16'h0001, 7'h00, 16'h7FFF, 4'b0011};

    repeat (3) @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_nzcv", {negative, zero, carry, overflow}, 4'b0000);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) issue(vecs[i]);
    repeat (2) @(negedge clk);

    // Backpressure: result held while out_ready is low, then back-to-back ORRs.
    out_ready = 1'b0;
    v = '{4'd0, 16'h0001, 16'h0002, 7'h00, 16'h0003, 4'b0000};
    issue(v);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold_result_c%0d", k), result, 16'h0003);
      check($sformatf("hold_out_valid_c%0d", k), out_valid, 1);
      check($sformatf("hold_in_ready_c%0d", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    v = '{4'd3, 16'h0001, 16'h0002, 7'h00, 16'h0003, 4'b0000}; issue(v);
    v = '{4'd3, 16'h8000, 16'h0000, 7'h00, 16'h8000, 4'b1000}; issue(v);
    v = '{4'd3, 16'h0000, 16'h0000, 7'h00, 16'h0000, 4'b0100}; issue(v);
    v = '{4'd3, 16'h00F0, 16'h000F, 7'h00, 16'h00FF, 4'b0000}; issue(v);

    // Reset five cycles into a MUL discards it and clears all state.
    v = '{4'd11, 16'h0003, 16'h0005, 7'h00, 16'h0000, 4'b1000}; issue(v);
    v = '{4'd7,  16'h1234, 16'h0000, 7'h00, 16'h1234, 4'b1000}; issue(v);
    opcode = 4'd2; operand_1 = 16'h0100; operand_2 = 16'h0100; in_valid = 1'b1;
    #1;
    check("mul_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mul_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_result", result, 16'h0000);
    check("midrst_nzcv", {negative, zero, carry, overflow}, 4'b0000);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    v = '{4'd0, 16'h7FFF, 16'h0001, 7'h00, 16'h8000, 4'b1001}; issue(v);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
